// File: rtl/latch_edge_monitor.sv
// Synchronizes and debounces the latch Q output, reporting confirmed edges as pulses and counting them.
// Optional feature macro: LATCH_EDGE_MON_GLITCH_CNT_EN adds glitch_cnt (count of aborted debounce checks).
module latch_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             clr_cnt,
   output logic             q_sync,
   output logic             q_stable,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_cnt,
`ifdef LATCH_EDGE_MON_GLITCH_CNT_EN
   output logic [CNT_W-1:0] glitch_cnt,
`endif
   output logic             cnt_ovf
);

   localparam int DEB_W = $clog2(DEBOUNCE + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE);

   typedef enum logic [1:0] {S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   state_t                 state_q, state_d;
   logic [DEB_W-1:0]       deb_q, deb_d, deb_inc;
   logic                   acc_rise, acc_fall;
   logic                   rise_q, fall_q, ovf_q;
   logic [CNT_W-1:0]       cnt_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
   end

   assign q_sync  = sync_q[SYNC_STAGES-1];
   assign deb_inc = deb_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOW;
         deb_q   <= '0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      acc_rise = 1'b0;
      acc_fall = 1'b0;
      case (state_q)
         S_LOW: if (q_sync) begin
            if (DEBOUNCE == 1) begin
               state_d  = S_HIGH;
               acc_rise = 1'b1;
            end else begin
               state_d = S_CHK_HI;
               deb_d   = DEB_W'(1);
            end
         end
         S_CHK_HI: begin
            if (!q_sync) begin
               state_d = S_LOW;
               deb_d   = '0;
            end else if (deb_inc == DEB_MAX) begin
               state_d  = S_HIGH;
               deb_d    = '0;
               acc_rise = 1'b1;
            end else begin
               deb_d = deb_inc;
            end
         end
         S_HIGH: if (!q_sync) begin
            if (DEBOUNCE == 1) begin
               state_d  = S_LOW;
               acc_fall = 1'b1;
            end else begin
               state_d = S_CHK_LO;
               deb_d   = DEB_W'(1);
            end
         end
         S_CHK_LO: begin
            if (q_sync) begin
               state_d = S_HIGH;
               deb_d   = '0;
            end else if (deb_inc == DEB_MAX) begin
               state_d  = S_LOW;
               deb_d    = '0;
               acc_fall = 1'b1;
            end else begin
               deb_d = deb_inc;
            end
         end
         default: begin
            state_d = S_LOW;
            deb_d   = '0;
         end
      endcase
   end

   // The stable level is implied by the state: a CHK state still reports the old level.
   always_comb begin
      q_stable = (state_q == S_HIGH) || (state_q == S_CHK_LO);
      rise     = rise_q;
      fall     = fall_q;
      edge_cnt = cnt_q;
      cnt_ovf  = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= acc_rise;
         fall_q <= acc_fall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (acc_rise || acc_fall) begin
         if (&cnt_q) ovf_q <= 1'b1;
         else        cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef LATCH_EDGE_MON_GLITCH_CNT_EN
   logic             abort;
   logic [CNT_W-1:0] glitch_q;

   assign abort = ((state_q == S_CHK_HI) && !q_sync) || ((state_q == S_CHK_LO) && q_sync);

   always_ff @(posedge clk) begin
      if (rst || clr_cnt)     glitch_q <= '0;
      else if (abort && !(&glitch_q)) glitch_q <= glitch_q + 1'b1;
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: doc/latch_edge_monitor.md
# latch_edge_monitor

Downstream consumer of the D latch output: takes the latch `Q` into the `clk` domain through a synchronizer chain and debounces it. It reports confirmed rising and falling transitions as single-cycle pulses and counts them. The block feeds the status/observation logic and checks that latch test sequences produce exactly the expected number of output transitions.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `q_in`; legal ≥ 2.
- `DEBOUNCE`, 4: consecutive equal `q_sync` samples needed to accept a level change; legal ≥ 1.
- `CNT_W`, 8: width of `edge_cnt`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `q_in` in 1: latch `Q`, asynchronous to `clk`.
- `clr_cnt` in 1: synchronous clear of `edge_cnt` and `cnt_ovf`.
- `q_sync` out 1: last synchronizer stage.
- `q_stable` out 1: debounced level.
- `rise` out 1: one-cycle pulse on confirmed 0→1.
- `fall` out 1: one-cycle pulse on confirmed 1→0.
- `edge_cnt` out `CNT_W`: confirmed transitions since reset or clear; saturating.
- `cnt_ovf` out 1: sticky flag; set when a transition arrives while `edge_cnt` is at its maximum.

## Operation
- Synchronizer: shift chain of `SYNC_STAGES` flops; `q_sync` is the last stage.
- FSM states:
  - `S_LOW`: `q_stable` = 0; `q_sync` = 1 moves to `S_CHK_HI` with `deb_cnt` = 1.
  - `S_CHK_HI`: `q_sync` = 1 increments `deb_cnt`; `q_sync` = 0 aborts to `S_LOW` (glitch).
  - `S_HIGH`: mirror of `S_LOW`.
  - `S_CHK_LO`: mirror of `S_CHK_HI`.
- Acceptance: the sample that brings the consecutive count to `DEBOUNCE` moves the FSM to `S_HIGH`/`S_LOW` on that edge. On the same edge `q_stable` updates and `rise`/`fall` asserts for exactly one cycle.
- `DEBOUNCE` = 1: accepts on the first differing sample; the `CHK` state is not dwelt in.
- Counter: each accepted transition increments `edge_cnt`.
  - At all-ones, the count holds and `cnt_ovf` sets.
  - `cnt_ovf` stays set until `clr_cnt` or `rst`.
- `clr_cnt` coinciding with an accepted transition: clear wins (`edge_cnt` = 0, `cnt_ovf` = 0). The `rise`/`fall` pulse still fires.
- `rise` and `fall` are never asserted together. A re-toggle is accepted no sooner than `DEBOUNCE` cycles after the previous acceptance.

## Timing
- Reset values: sync chain 0, FSM `S_LOW`, `deb_cnt` 0. All outputs 0: `q_sync`, `q_stable`, `rise`, `fall`, `edge_cnt`, `cnt_ovf`.
- Latency: `q_in` settled before edge 0 → `q_sync` high after edge `SYNC_STAGES-1`.
  - `q_stable`/`rise` high after edge `SYNC_STAGES+DEBOUNCE-1`; defaults give edge 5.
  - `edge_cnt` increments on that same edge.
- Glitch: a `q_sync` pulse shorter than `DEBOUNCE` cycles produces no output change and no count.
- `rst` mid-check: aborts the check with no pulse; the next cycle behaves as after power-up.
- `q_in` = 1 through reset: the synchronizer refills after release and the high level is reported as a normal `rise` with latency as above.

## Configuration
- Macro: `LATCH_EDGE_MON_GLITCH_CNT_EN`.
- Defined:
  - Adds output `glitch_cnt` (out, `CNT_W`): counts aborted `CHK` states.
  - Saturates at its maximum.
  - Reset value 0; cleared by `clr_cnt`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: `rst` high 3 cycles with `q_in` = 0 → all outputs 0; with `q_in` held 0 they stay 0 for 20 cycles.
- Clean rise/fall, defaults: `q_in` 0→1 before edge 0 → `rise` one cycle after edge 5, `q_stable` = 1, `edge_cnt` = 1. `q_in` 1→0 20 cycles later → `fall` after 5 edges, `edge_cnt` = 2.
- Glitch rejection: `q_in` high for 2 cycles then low → no `rise`, `edge_cnt` stays 0. With `LATCH_EDGE_MON_GLITCH_CNT_EN`, `glitch_cnt` = 1.
- Saturation, `CNT_W` = 2: 4 clean toggles → `edge_cnt` = 3, `cnt_ovf` = 1. `clr_cnt` pulse → both 0.
- Clear collision: `clr_cnt` asserted on the acceptance edge → `rise` pulses, `edge_cnt` = 0.
- Reset mid-check: `rst` asserted while in `S_CHK_HI` → no `rise`. With `q_in` still 1 after release, `rise` fires 5 edges after the first post-reset edge.
